// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: MODE 0 follows the ctrl stall vector,
// MODE 1 is a valid/ready stage backed by a 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int                  DATA_W     = 113,
  parameter int                  STAGE_IDX  = 3,
  parameter int                  STALL_W    = 6,
  parameter int                  MODE       = 0,
  parameter logic [DATA_W-1:0]   RESET_DATA = '0,
  parameter int                  CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] main_q;
  logic              main_vld;
  logic [CNT_W-1:0]  cnt_q;
  logic              bump;

  // Each mode only looks at part of the control inputs.
  logic unused_ok;
  assign unused_ok = ^{stall, out_ready};

  generate
    if (MODE == 0) begin : g_stall
      logic s, d;
      assign s        = stall[STAGE_IDX];
      assign d        = stall[STAGE_IDX+1];
      assign in_ready = ~s & ~rst;
      assign bump     = ~flush & s & ~d;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          main_q   <= RESET_DATA;
          main_vld <= 1'b0;
        end else if (!s) begin
          main_q   <= in_data;
          main_vld <= in_valid;
        end else if (!d) begin
          main_q   <= RESET_DATA;
          main_vld <= 1'b0;
        end
      end
    end else begin : g_skid
      localparam logic [1:0] EMPTY = 2'd0;
      localparam logic [1:0] ONE   = 2'd1;
      localparam logic [1:0] FULL  = 2'd2;

      logic [1:0]        occ;
      logic [DATA_W-1:0] skid_q;
      logic              accept, drain;

      // Ready depends only on registered occupancy, never on out_ready.
      assign in_ready = (occ != FULL) & ~rst;
      assign main_vld = (occ != EMPTY);
      assign accept   = in_valid & in_ready;
      assign drain    = main_vld & out_ready;
      assign bump     = ~flush & ~main_vld & out_ready;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          occ    <= EMPTY;
          main_q <= RESET_DATA;
          skid_q <= RESET_DATA;
        end else begin
          case (occ)
            EMPTY: if (accept) begin
              occ    <= ONE;
              main_q <= in_data;
            end
            ONE: begin
              if (accept && drain) begin
                main_q <= in_data;
              end else if (accept) begin
                occ    <= FULL;
                skid_q <= in_data;
              end else if (drain) begin
                occ    <= EMPTY;
                main_q <= RESET_DATA;
              end
            end
            FULL: if (drain) begin
              occ    <= ONE;
              main_q <= skid_q;
              skid_q <= RESET_DATA;
            end
            default: occ <= EMPTY;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (bump && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
  end

  assign out_valid  = main_vld;
  assign out_data   = main_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: stall-mode, saturating-counter and skid-mode instances,
// each checked every cycle against a queue/rule model plus directed literal checks.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A: stall mode, full width
  logic         a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid;
  logic         a_out_ready = 1'b1;
  logic [5:0]   a_stall;
  logic [112:0] a_in_data, a_out_data;
  logic [15:0]  a_cnt;

  pipe_stage_reg #(.DATA_W(113), .STAGE_IDX(3), .STALL_W(6), .MODE(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(a_rst), .stall(a_stall), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .bubble_cnt(a_cnt));

  // B: skid mode
  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [5:0]  b_stall = 6'h3f;
  logic [15:0] b_in_data, b_out_data;
  logic [15:0] b_cnt;

  pipe_stage_reg #(.DATA_W(16), .STAGE_IDX(3), .STALL_W(6), .MODE(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(b_rst), .stall(b_stall), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .bubble_cnt(b_cnt));

  // C: stall mode, narrow counter for saturation
  logic       c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid;
  logic       c_out_ready = 1'b1;
  logic [5:0] c_stall;
  logic [7:0] c_in_data, c_out_data;
  logic [3:0] c_cnt;

  pipe_stage_reg #(.DATA_W(8), .STAGE_IDX(3), .STALL_W(6), .MODE(0), .CNT_W(4)) u_c (
    .clk(clk), .rst(c_rst), .stall(c_stall), .flush(c_flush),
    .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
    .bubble_cnt(c_cnt));

  // Reference models
  logic [112:0] ma_d;  bit ma_v;  int ma_c;
  logic [7:0]   mc_d;  bit mc_v;  int mc_c;
  logic [15:0]  mq[$]; int mb_c;
  bit           mb_acc, mb_drn;

  always @(posedge clk) begin
    if (a_rst) begin ma_d = '0; ma_v = 0; ma_c = 0; end
    else if (a_flush) begin ma_d = '0; ma_v = 0; end
    else if (!a_stall[3]) begin ma_d = a_in_data; ma_v = a_in_valid; end
    else if (!a_stall[4]) begin ma_d = '0; ma_v = 0; if (ma_c < 65535) ma_c++; end

    if (c_rst) begin mc_d = '0; mc_v = 0; mc_c = 0; end
    else if (c_flush) begin mc_d = '0; mc_v = 0; end
    else if (!c_stall[3]) begin mc_d = c_in_data; mc_v = c_in_valid; end
    else if (!c_stall[4]) begin mc_d = '0; mc_v = 0; if (mc_c < 15) mc_c++; end

    if (b_rst) begin mq.delete(); mb_c = 0; end
    else if (b_flush) mq.delete();
    else begin
      mb_acc = b_in_valid && (mq.size() < 2);
      mb_drn = (mq.size() > 0) && b_out_ready;
      if (mq.size() == 0 && b_out_ready && mb_c < 65535) mb_c++;
      if (mb_drn) void'(mq.pop_front());
      if (mb_acc) mq.push_back(b_in_data);
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("a_valid", a_out_valid, ma_v);
    chk("a_data",  a_out_data,  ma_d);
    chk("a_cnt",   a_cnt,       ma_c);
    chk("a_ready", a_in_ready,  !a_stall[3] && !a_rst);
    chk("c_valid", c_out_valid, mc_v);
    chk("c_data",  c_out_data,  mc_d);
    chk("c_cnt",   c_cnt,       mc_c);
    chk("c_ready", c_in_ready,  !c_stall[3] && !c_rst);
    chk("b_valid", b_out_valid, mq.size() != 0);
    chk("b_data",  b_out_data,  (mq.size() != 0) ? mq[0] : 16'h0);
    chk("b_cnt",   b_cnt,       mb_c);
    chk("b_ready", b_in_ready,  (mq.size() < 2) && !b_rst);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int sent, rcvd, cyc;
  bit acc, drn;
  logic [15:0] got;

  initial begin
    a_rst = 1; a_flush = 0; a_stall = '0; a_in_valid = 0; a_in_data = '0;
    b_rst = 1; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_rst = 1; c_flush = 0; c_stall = '0; c_in_valid = 0; c_in_data = '0;
    tick;
    chk_en = 1;
    tick;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data",  a_out_data,  0);
    chk("rst_a_cnt",   a_cnt,       0);
    chk("rst_a_ready", a_in_ready,  0);
    chk("rst_b_ready", b_in_ready,  0);
    a_rst = 0; b_rst = 0;

    // Load
    a_in_data = 113'h1_0000_0ABC; a_in_valid = 1;
    tick;
    chk("t1_data",  a_out_data,  113'h1_0000_0ABC);
    chk("t1_valid", a_out_valid, 1);

    // Own and downstream stalled: hold
    a_stall = 6'b011111; a_in_data = 113'h2222;
    repeat (3) begin
      tick;
      chk("t2_hold_data",  a_out_data,  113'h1_0000_0ABC);
      chk("t2_hold_valid", a_out_valid, 1);
    end
    // Own stalled, downstream free: bubble
    a_stall = 6'b001111;
    tick;
    chk("t2_bub_valid", a_out_valid, 0);
    chk("t2_bub_data",  a_out_data,  0);
    chk("t2_bub_cnt",   a_cnt,       1);
    a_stall = 6'b000000; a_in_data = 113'h3_3333;
    tick;
    chk("t2_load_data", a_out_data, 113'h3_3333);
    chk("t2_load_cnt",  a_cnt,      1);

    // Flush beats hold
    a_stall = 6'b011111; a_flush = 1;
    tick;
    chk("t3_valid", a_out_valid, 0);
    chk("t3_data",  a_out_data,  0);
    chk("t3_cnt",   a_cnt,       1);
    a_flush = 0;
    a_stall = 6'b000000; a_in_valid = 0; a_in_data = 113'h5;
    tick;
    chk("t3_inv_valid", a_out_valid, 0);
    chk("t3_inv_data",  a_out_data,  5);
    chk("t3_inv_cnt",   a_cnt,       1);

    // Saturating counter and mid-stream reset
    c_rst = 0; c_stall = 6'b001111;
    repeat (20) tick;
    chk("t6_sat", c_cnt, 15);
    c_stall = 6'b000000; c_in_valid = 1; c_in_data = 8'h5A;
    tick;
    chk("t6_load", c_out_data, 8'h5A);
    c_rst = 1;
    tick;
    chk("t6_rst_valid", c_out_valid, 0);
    chk("t6_rst_data",  c_out_data,  0);
    chk("t6_rst_cnt",   c_cnt,       0);
    c_rst = 0;

    // Skid: fill with out_ready low, third word refused
    b_out_ready = 0; b_in_valid = 1; b_in_data = 16'h000A;
    tick;
    b_in_data = 16'h000B;
    tick;
    chk("t4_full_ready", b_in_ready, 0);
    b_in_data = 16'h000C;
    tick;
    chk("t4_c_refused", b_in_ready, 0);
    chk("t4_head_a",    b_out_data, 16'h000A);
    b_out_ready = 1;
    tick;
    chk("t4_head_b", b_out_data, 16'h000B);
    tick;
    chk("t4_head_c", b_out_data, 16'h000C);
    b_in_valid = 0;
    tick;
    chk("t4_empty", b_out_valid, 0);

    // Flush with a word presented drops everything
    b_out_ready = 0; b_in_valid = 1; b_in_data = 16'h0001;
    tick;
    b_in_data = 16'h0002;
    tick;
    b_flush = 1; b_in_data = 16'h0003;
    tick;
    chk("flush_b_valid", b_out_valid, 0);
    chk("flush_b_ready", b_in_ready,  1);
    b_flush = 0; b_in_valid = 0;
    tick;

    // Streaming with toggling back-pressure and random input gaps
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 100 && cyc < 2000) begin
      b_out_ready = (cyc[0] == 1'b0);
      b_in_valid  = (sent < 100) && ($urandom_range(3) != 0);
      b_in_data   = 16'h1000 + 16'(sent);
      #1;
      acc = b_in_valid && b_in_ready;
      drn = b_out_valid && b_out_ready;
      got = b_out_data;
      tick;
      if (drn) begin
        chk("t5_order", got, 16'h1000 + 16'(rcvd));
        rcvd++;
      end
      if (acc) sent++;
      cyc++;
    end
    chk("t5_count", rcvd, 100);
    b_in_valid = 0;
    tick;
    tick;

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
